// File: rtl/mul_iterative.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU: retires BPC multiplier
// bits per cycle on operand magnitudes, then fixes the sign in one extra cycle.
module mul_iterative #(
  parameter int XLEN       = 32,
  parameter int BPC        = 2,
  parameter int EARLY_TERM = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stb_i,
  input  logic            cyc_i,
  input  logic [XLEN-1:0] op_1_i,
  input  logic            op_1_is_signed_i,
  input  logic [XLEN-1:0] op_2_i,
  input  logic            op_2_is_signed_i,
  input  logic            result_upper_i,
  output logic [XLEN-1:0] result_o,
  output logic            ack_o,
  output logic            busy_o
);

  localparam int PW    = 2 * XLEN;
  localparam int NITER = XLEN / BPC;
  localparam int IW    = $clog2(NITER) + 1;

  localparam logic [XLEN-1:0] ONE_X     = XLEN'(1);
  localparam logic [PW-1:0]   ONE_P     = PW'(1);
  localparam logic [IW-1:0]   ONE_I     = IW'(1);
  localparam logic [IW-1:0]   LAST_ITER = IW'(NITER - 1);

  generate
    if (!((BPC == 1) || (BPC == 2) || (BPC == 4) || (BPC == 8)) || (XLEN % BPC != 0)) begin : g_bad_bpc
      $error("mul_iterative: BPC must be 1, 2, 4 or 8 and must divide XLEN");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   a_reg, a_next;
  logic [XLEN-1:0] b_reg, b_next;
  logic [PW-1:0]   acc_reg, acc_next;
  logic [IW-1:0]   iter_reg, iter_next;
  logic            neg_reg, neg_next;
  logic            upper_reg, upper_next;
  logic            ack_reg, ack_next;
  logic [XLEN-1:0] result_reg, result_next;

  logic [XLEN-1:0] op_1_mag, op_2_mag;
  logic            op_1_neg, op_2_neg;
  logic [PW-1:0]   pp_term [BPC];
  logic [PW-1:0]   pp_sum;
  logic [XLEN-1:0] b_shift;
  logic            req_live;
  logic            last_iter;

  // Magnitudes: 0x80..0 negates to itself, which read as unsigned is the right value.
  assign op_1_neg = op_1_is_signed_i & op_1_i[XLEN-1];
  assign op_2_neg = op_2_is_signed_i & op_2_i[XLEN-1];
  assign op_1_mag = op_1_neg ? (~op_1_i + ONE_X) : op_1_i;
  assign op_2_mag = op_2_neg ? (~op_2_i + ONE_X) : op_2_i;

  generate
    for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
      assign pp_term[gi] = b_reg[gi] ? (a_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < BPC; i++) begin
      pp_sum = pp_sum + pp_term[i];
    end
  end

  assign b_shift   = b_reg >> BPC;
  assign req_live  = stb_i & cyc_i;
  // Remaining multiplier bits all zero means further iterations would add nothing.
  assign last_iter = (iter_reg == LAST_ITER) || ((EARLY_TERM != 0) && (b_shift == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      iter_reg   <= '0;
      neg_reg    <= 1'b0;
      upper_reg  <= 1'b0;
      ack_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      acc_reg    <= acc_next;
      iter_reg   <= iter_next;
      neg_reg    <= neg_next;
      upper_reg  <= upper_next;
      ack_reg    <= ack_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    acc_next    = acc_reg;
    iter_next   = iter_reg;
    neg_next    = neg_reg;
    upper_next  = upper_reg;
    ack_next    = ack_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        // A held strobe keeps ack up; it only clears once the requester lets go.
        if (ack_reg) begin
          ack_next = stb_i;
        end
        if (req_live && !ack_reg) begin
          a_next     = {{XLEN{1'b0}}, op_1_mag};
          b_next     = op_2_mag;
          neg_next   = op_1_neg ^ op_2_neg;
          upper_next = result_upper_i;
          acc_next   = '0;
          iter_next  = '0;
          state_next = MUL;
        end
      end

      MUL: begin
        if (!req_live) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end else begin
          acc_next  = acc_reg + pp_sum;
          a_next    = a_reg << BPC;
          b_next    = b_shift;
          iter_next = iter_reg + ONE_I;
          if (last_iter) begin
            state_next = neg_reg ? NEG : DONE;
          end
        end
      end

      NEG: begin
        if (!req_live) begin
          ack_next   = 1'b0;
          state_next = IDLE;
        end else begin
          acc_next   = ~acc_reg + ONE_P;
          state_next = DONE;
        end
      end

      DONE: begin
        result_next = upper_reg ? acc_reg[PW-1:XLEN] : acc_reg[XLEN-1:0];
        ack_next    = 1'b1;
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign result_o = result_reg;
  assign ack_o    = ack_reg & stb_i;
  assign busy_o   = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_iterative.sv
// Bench for mul_iterative: three configurations share one request bus and are
// checked against an arithmetic product model and a closed-form latency model.
module tb_mul_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc;
  logic [31:0] op1, op2;
  logic        s1, s2, up;

  logic [31:0] res_w  [3];
  logic        ack_w  [3];
  logic        busy_w [3];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] obs_res [3];
  int          obs_lat [3];

  always #5 clk = ~clk;

  mul_iterative #(.XLEN(32), .BPC(1), .EARLY_TERM(1)) u_b1_et (
    .clk_i(clk), .rst_ni(rst_n), .stb_i(stb), .cyc_i(cyc),
    .op_1_i(op1), .op_1_is_signed_i(s1), .op_2_i(op2), .op_2_is_signed_i(s2),
    .result_upper_i(up), .result_o(res_w[0]), .ack_o(ack_w[0]), .busy_o(busy_w[0])
  );

  mul_iterative #(.XLEN(32), .BPC(2), .EARLY_TERM(1)) u_b2_et (
    .clk_i(clk), .rst_ni(rst_n), .stb_i(stb), .cyc_i(cyc),
    .op_1_i(op1), .op_1_is_signed_i(s1), .op_2_i(op2), .op_2_is_signed_i(s2),
    .result_upper_i(up), .result_o(res_w[1]), .ack_o(ack_w[1]), .busy_o(busy_w[1])
  );

  mul_iterative #(.XLEN(32), .BPC(2), .EARLY_TERM(0)) u_b2_full (
    .clk_i(clk), .rst_ni(rst_n), .stb_i(stb), .cyc_i(cyc),
    .op_1_i(op1), .op_1_is_signed_i(s1), .op_2_i(op2), .op_2_is_signed_i(s2),
    .result_upper_i(up), .result_o(res_w[2]), .ack_o(ack_w[2]), .busy_o(busy_w[2])
  );

  function automatic int cfg_bpc(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int cfg_et(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  // Reference product: sign/zero-extend to 64 bits and multiply modulo 2^64.
  function automatic logic [31:0] exp_result(input logic [31:0] o1, input logic [31:0] o2,
                                             input logic f1, input logic f2, input logic fu);
    logic [63:0] e1, e2, p;
    e1 = f1 ? {{32{o1[31]}}, o1} : {32'h0, o1};
    e2 = f2 ? {{32{o2[31]}}, o2} : {32'h0, o2};
    p  = e1 * e2;
    return fu ? p[63:32] : p[31:0];
  endfunction

  // Edges from the start-sampling edge until ack_o is first high: 2 + k + neg.
  function automatic int exp_lat(input logic [31:0] o1, input logic [31:0] o2,
                                 input logic f1, input logic f2, input int bpc, input int et);
    logic [31:0] b_abs;
    int msb;
    int k;
    bit neg;
    b_abs = (f2 && o2[31]) ? (32'd0 - o2) : o2;
    msb = -1;
    for (int i = 0; i < 32; i++) begin
      if (b_abs[i]) msb = i;
    end
    if (et != 0) k = (msb < 0) ? 1 : (msb + bpc) / bpc;
    else         k = 32 / bpc;
    neg = (f1 && o1[31]) != (f2 && o2[31]);
    return 2 + k + (neg ? 1 : 0);
  endfunction

  // Issue one request, scramble the inputs after the start edge, record the first
  // ack edge and result of each instance, then release the strobe.
  task automatic do_op(input logic [31:0] o1, input logic [31:0] o2,
                       input logic f1, input logic f2, input logic fu);
    int edge_n;
    bit seen [3];
    @(negedge clk);
    op1 = o1; op2 = o2; s1 = f1; s2 = f2; up = fu;
    stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      seen[i] = 1'b0; obs_lat[i] = -1; obs_res[i] = '0;
    end
    edge_n = 0;
    while (!(seen[0] && seen[1] && seen[2]) && edge_n < 100) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      if (edge_n == 1) begin
        op1 = $urandom; op2 = $urandom; s1 = ~f1; s2 = ~f2; up = ~fu;
      end
      for (int i = 0; i < 3; i++) begin
        if (ack_w[i] === 1'b1 && !seen[i]) begin
          seen[i] = 1'b1; obs_lat[i] = edge_n; obs_res[i] = res_w[i];
        end
      end
    end
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0;
    op1 = '0; op2 = '0; s1 = 1'b0; s2 = 1'b0; up = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({busy_w[i], ack_w[i], res_w[i]} !== 34'h0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d: got busy=%b ack=%b res=%h, want 0 0 00000000",
                 i, busy_w[i], ack_w[i], res_w[i]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] o1;
    logic [31:0] o2;
    logic        f1;
    logic        f2;
    logic        fu;
    logic [31:0] want;
  } vec_t;

  task automatic test_directed;
    vec_t vecs [10];
    vecs[0] = '{32'd7,        32'd6,        1'b0, 1'b0, 1'b0, 32'd42};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001};
    vecs[6] = '{32'h00001234, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000};
    vecs[7] = '{32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000000};
    vecs[8] = '{32'h00000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h00000000};
    vecs[9] = '{32'hFFFFFFF9, 32'd6,        1'b1, 1'b1, 1'b0, 32'hFFFFFFD6};
    for (int n = 0; n < 10; n++) begin
      do_op(vecs[n].o1, vecs[n].o2, vecs[n].f1, vecs[n].f2, vecs[n].fu);
      $display("[TB] directed %0d: %h*%h s=%b%b up=%b -> %h %h %h lat %0d %0d %0d", n,
               vecs[n].o1, vecs[n].o2, vecs[n].f1, vecs[n].f2, vecs[n].fu,
               obs_res[0], obs_res[1], obs_res[2], obs_lat[0], obs_lat[1], obs_lat[2]);
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (obs_res[i] !== vecs[n].want) begin
          tests_failed++;
          $display("FAIL dir_result[%0d] dut%0d: got %h, want %h", n, i, obs_res[i], vecs[n].want);
        end
        tests_run++;
        if (obs_lat[i] !== exp_lat(vecs[n].o1, vecs[n].o2, vecs[n].f1, vecs[n].f2,
                                   cfg_bpc(i), cfg_et(i))) begin
          tests_failed++;
          $display("FAIL dir_latency[%0d] dut%0d: got %0d, want %0d", n, i, obs_lat[i],
                   exp_lat(vecs[n].o1, vecs[n].o2, vecs[n].f1, vecs[n].f2, cfg_bpc(i), cfg_et(i)));
        end
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] o1, o2, want;
    logic f1, f2, fu;
    int lat;
    for (int n = 0; n < 24; n++) begin
      o1 = $urandom;
      o2 = $urandom;
      if (n % 2 == 1) o2 = o2 >> $urandom_range(0, 31);
      f1 = 1'($urandom_range(0, 1));
      f2 = 1'($urandom_range(0, 1));
      fu = 1'($urandom_range(0, 1));
      want = exp_result(o1, o2, f1, f2, fu);
      do_op(o1, o2, f1, f2, fu);
      $display("[TB] random %0d: %h*%h s=%b%b up=%b -> %h %h %h want %h", n, o1, o2, f1, f2, fu,
               obs_res[0], obs_res[1], obs_res[2], want);
      for (int i = 0; i < 3; i++) begin
        lat = exp_lat(o1, o2, f1, f2, cfg_bpc(i), cfg_et(i));
        tests_run++;
        if (obs_res[i] !== want) begin
          tests_failed++;
          $display("FAIL rnd_result[%0d] dut%0d: got %h, want %h", n, i, obs_res[i], want);
        end
        tests_run++;
        if (obs_lat[i] !== lat) begin
          tests_failed++;
          $display("FAIL rnd_latency[%0d] dut%0d: got %0d, want %0d", n, i, obs_lat[i], lat);
        end
      end
    end
  endtask

  task automatic test_abort;
    do_op(32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    op1 = 32'h00001234; op2 = 32'hFFFF0000; s1 = 1'b0; s2 = 1'b0; up = 1'b0;
    stb = 1'b1; cyc = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("[TB] abort: busy %b%b%b res %h %h %h", busy_w[0], busy_w[1], busy_w[2],
             res_w[0], res_w[1], res_w[2]);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (busy_w[i] !== 1'b0 || res_w[i] !== 32'd81) begin
        tests_failed++;
        $display("FAIL abort_state dut%0d: got busy=%b res=%h, want busy=0 res=00000051",
                 i, busy_w[i], res_w[i]);
      end
    end
    // Strobe without cycle: no start, and ack_o exposes ack_q which must be clear.
    stb = 1'b1; cyc = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (ack_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL abort_no_ack dut%0d: got ack=%b busy=%b, want 0 0", i, ack_w[i], busy_w[i]);
        end
      end
    end
    stb = 1'b0;
    do_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    $display("[TB] after abort: 3*5 -> %h %h %h", obs_res[0], obs_res[1], obs_res[2]);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs_res[i] !== 32'd15 ||
          obs_lat[i] !== exp_lat(32'd3, 32'd5, 1'b0, 1'b0, cfg_bpc(i), cfg_et(i))) begin
        tests_failed++;
        $display("FAIL abort_fresh dut%0d: got res=%h lat=%0d, want res=0000000f lat=%0d", i,
                 obs_res[i], obs_lat[i], exp_lat(32'd3, 32'd5, 1'b0, 1'b0, cfg_bpc(i), cfg_et(i)));
      end
    end
  endtask

  task automatic test_back_to_back;
    int edge_n;
    @(negedge clk);
    op1 = 32'd2; op2 = 32'd3; s1 = 1'b0; s2 = 1'b0; up = 1'b0;
    stb = 1'b1; cyc = 1'b1;
    edge_n = 0;
    while (!(ack_w[0] === 1'b1 && ack_w[1] === 1'b1 && ack_w[2] === 1'b1) && edge_n < 100) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
    end
    tests_run++;
    if (edge_n >= 100) begin
      tests_failed++;
      $display("FAIL hold_ack_timeout: got no ack within %0d edges, want ack", edge_n);
    end
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (ack_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || res_w[i] !== 32'd6) begin
          tests_failed++;
          $display("FAIL hold_stb dut%0d: got ack=%b busy=%b res=%h, want 1 0 00000006",
                   i, ack_w[i], busy_w[i], res_w[i]);
        end
      end
    end
    $display("[TB] held strobe: ack %b%b%b res %h", ack_w[0], ack_w[1], ack_w[2], res_w[0]);
    stb = 1'b0; cyc = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ack_w[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL ack_comb_drop dut%0d: got %b, want 0", i, ack_w[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    stb = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ack_w[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL ack_q_clear dut%0d: got %b, want 0", i, ack_w[i]);
      end
    end
    stb = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF; s1 = 1'b0; s2 = 1'b0; up = 1'b1;
    stb = 1'b1; cyc = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (busy_w[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_in_mul dut%0d: got %b, want 1", i, busy_w[i]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset: busy %b%b%b ack %b%b%b res %h", busy_w[0], busy_w[1], busy_w[2],
             ack_w[0], ack_w[1], ack_w[2], res_w[0]);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({busy_w[i], ack_w[i], res_w[i]} !== 34'h0) begin
        tests_failed++;
        $display("FAIL async_reset dut%0d: got busy=%b ack=%b res=%h, want 0 0 00000000",
                 i, busy_w[i], ack_w[i], res_w[i]);
      end
    end
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd11, 32'd13, 1'b0, 1'b0, 1'b0);
    $display("[TB] after reset: 11*13 -> %h %h %h", obs_res[0], obs_res[1], obs_res[2]);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (obs_res[i] !== 32'd143) begin
        tests_failed++;
        $display("FAIL reset_recover dut%0d: got %h, want 0000008f", i, obs_res[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_abort;
    test_back_to_back;
    test_reset_mid_op;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_iterative.md
Name: mul_iterative

Overview:
- Parametrised successor to the single-bit shift-add multiplier in the RV32M execute path.
- Serves MUL, MULH, MULHSU and MULHU.
- Adds three things the old unit lacks:
  - configurable operand width (XLEN);
  - configurable bits retired per cycle (radix);
  - early termination once the remaining multiplier bits are zero.
- Also adds clean abort when the requester drops stb_i or cyc_i mid-operation, and a busy_o indication for pipeline stall logic.

Parameters:
- XLEN, 32: operand width in bits; result is 2*XLEN internally.
- BPC, 2: multiplier bits retired per iteration. Legal values are 1, 2, 4 or 8, and BPC must divide XLEN. Illegal values are an elaboration error.
- EARLY_TERM, 1: 1 enables early termination; 0 forces the full XLEN/BPC iterations.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_ni, input, 1: reset, asynchronous, active-low.
- stb_i, input, 1: request strobe; held high by the requester until ack_o is seen.
- cyc_i, input, 1: bus cycle valid; asserted together with stb_i.
- op_1_i, input, XLEN: multiplicand.
- op_1_is_signed_i, input, 1: op_1_i is two's complement.
- op_2_i, input, XLEN: multiplier.
- op_2_is_signed_i, input, 1: op_2_i is two's complement.
- result_upper_i, input, 1: 1 returns product[2*XLEN-1:XLEN]; 0 returns product[XLEN-1:0].
- result_o, output, XLEN: registered result; holds its value until the next DONE.
- ack_o, output, 1: completion; equals ack_q AND stb_i.
- busy_o, output, 1: high in every state other than IDLE.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE, ack_q=0, result_o=0, busy_o=0.
  - All datapath registers are cleared.
  - Reset asserted mid-operation abandons the operation; no ack is produced.
- States: IDLE, MUL, NEG, DONE.
- IDLE:
  - If ack_q=1, then ack_q <= stb_i, so ack clears the cycle after stb_i drops.
  - Start condition is stb_i & cyc_i & ~ack_q. This prevents a held stb_i from restarting the operation.
  - On start, capture:
    - a = |op_1_i| (zero-extended to 2*XLEN);
    - b = |op_2_i|. Magnitude is taken only when the operand's is_signed flag is 1 and its MSB is 1.
    - neg = (s1&op_1_i[XLEN-1]) ^ (s2&op_2_i[XLEN-1]);
    - upper = result_upper_i;
    - acc = 0, iter = 0.
  - Go to MUL.
  - Operands and control are latched at start; input changes after start are ignored.
- MUL, one cycle per iteration:
  - acc += a * b[BPC-1:0]; a <<= BPC; b >>= BPC; iter++.
  - The partial product is a BPC-by-2*XLEN unsigned multiply, formed combinationally from shifted adds.
  - The loop exits when iter == XLEN/BPC-1.
  - With EARLY_TERM=1, the loop also exits when the post-shift b == 0.
  - On exit: go to NEG if neg, else go to DONE.
- NEG: acc <= ~acc + 1 (2*XLEN wide); go to DONE.
- DONE: result_o <= upper ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]; ack_q <= 1; go to IDLE.
- Latency:
  - k = number of MUL cycles:
    - with EARLY_TERM=1, k = max(1, ceil((msb_index(b_abs)+1)/BPC)), with b_abs=0 giving k=1;
    - otherwise k = XLEN/BPC.
  - ack_o first rises after 2+k+neg rising edges, counted from the edge that samples the start.
- Abort:
  - If stb_i or cyc_i is low on any edge in MUL or NEG, go to IDLE with ack_q=0.
  - result_o is not updated.
  - DONE always completes.
- Arithmetic:
  - All accumulation is 2*XLEN bits modulo 2^(2*XLEN).
  - The magnitude of the most negative value (0x80..0) is the same bit pattern, interpreted as unsigned; this is correct and needs no special case.
- Back-to-back requests:
  - A new start requires stb_i low for at least one edge after ack.
  - ack_o=0 whenever stb_i=0, combinationally.

Test Plan:
- Unsigned low half, BPC=1, EARLY_TERM=1: op1=7, op2=6 → result_o=42. op2 msb index is 2, so k=3 and ack_o rises after edge 5.
- MULHU: op1=op2=0xFFFFFFFF, both unsigned, upper=1 → 0xFFFFFFFE. Same operands with upper=0 → 0x00000001. With BPC=2 and no early exit, k=16 and ack_o rises after edge 18.
- MULH: op1=op2=0x80000000, both signed → 0x40000000. MULHSU: op1=0xFFFFFFFF signed, op2=0xFFFFFFFF unsigned, upper=1 → 0xFFFFFFFF; upper=0 → 0x00000001. This case goes through NEG, adding one cycle.
- Zero operand: op2=0 → result 0 with k=1, ack after edge 3. Also check op1=0 with op2=0x80000000 → 0. Repeat with EARLY_TERM=0 and confirm full latency.
- Abort: drop stb_i during the 3rd MUL cycle. Required: state returns to IDLE, ack_o never rises, result_o keeps its previous value. A following fresh request of 3*5 → 15.
- Reset and handshake:
  - Pull rst_ni low mid-MUL. Required: busy_o=0, ack_o=0 and result_o=0 immediately, without waiting for a clock edge.
  - Hold stb_i high after ack. Required: no second operation starts, and ack_o stays high until stb_i drops.
